// File: rtl/int_mult.sv
// int_mult: signed Baugh-Wooley multiplier with a carry-save tree, a ripple-carry final adder
// and an optional output register.
module int_mult #(
  parameter int W_IN_A  = 8,
  parameter int W_IN_B  = 5,
  parameter int OUT_REG = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [W_IN_A-1:0]          in_a,
  input  logic [W_IN_B-1:0]          in_b,
  output logic [W_IN_A+W_IN_B-1:0]   out_x
);
  localparam int W_OUT_X = W_IN_A + W_IN_B;
  localparam int N_ROWS  = W_IN_B + 1;
  function automatic int rows_at(input int l);
    int n;
    n = N_ROWS;
    for (int k = 0; k < l; k++) n = 2 * (n / 3) + n % 3;
    return n;
  endfunction
  function automatic int levels(input int n0);
    int n;
    int l;
    n = n0;
    l = 0;
    while (n > 2) begin
      n = 2 * (n / 3) + n % 3;
      l++;
    end
    return l;
  endfunction
  localparam int N_LVL = levels(N_ROWS);
  // Folds every -2^k term of the inverted MSB row/column, plus the sign weight, into one constant row
  localparam logic [W_OUT_X-1:0] K_CORR = (W_OUT_X'(1) << (W_IN_A - 1))
                                        + (W_OUT_X'(1) << (W_IN_B - 1))
                                        + (W_OUT_X'(1) << (W_OUT_X - 1));
  logic [W_OUT_X-1:0] w_lvl [N_LVL+1][N_ROWS];
  logic [W_OUT_X-1:0] w_sum;
  logic [W_OUT_X-1:0] w_c;
  for (genvar j = 0; j < W_IN_B; j++) begin : g_row
    logic [W_IN_A-1:0] w_pp;
    for (genvar i = 0; i < W_IN_A; i++) begin : g_bit
      assign w_pp[i] = (in_a[i] & in_b[j]) ^ ((i == W_IN_A - 1) != (j == W_IN_B - 1));
    end
    assign w_lvl[0][j] = {{W_IN_B{1'b0}}, w_pp} << j;
  end
  assign w_lvl[0][W_IN_B] = K_CORR;
  for (genvar l = 0; l < N_LVL; l++) begin : g_lvl
    localparam int NI = rows_at(l);
    localparam int NG = NI / 3;
    localparam int NO = 2 * NG + NI % 3;
    for (genvar g = 0; g < NG; g++) begin : g_csa
      logic [W_OUT_X-1:0] w_x, w_y, w_z;
      assign w_x = w_lvl[l][3*g];
      assign w_y = w_lvl[l][3*g+1];
      assign w_z = w_lvl[l][3*g+2];
      assign w_lvl[l+1][2*g]   = w_x ^ w_y ^ w_z;
      assign w_lvl[l+1][2*g+1] = ((w_x & w_y) | (w_x & w_z) | (w_y & w_z)) << 1;
    end
    for (genvar r = 0; r < NI % 3; r++) begin : g_pass
      assign w_lvl[l+1][2*NG+r] = w_lvl[l][3*NG+r];
    end
    for (genvar r = NO; r < N_ROWS; r++) begin : g_zero
      assign w_lvl[l+1][r] = '0;
    end
  end
  assign w_c[0] = 1'b0;
  for (genvar i = 0; i < W_OUT_X; i++) begin : g_rca
    assign w_sum[i] = w_lvl[N_LVL][0][i] ^ w_lvl[N_LVL][1][i] ^ w_c[i];
    if (i < W_OUT_X - 1) begin : g_cy
      assign w_c[i+1] = (w_lvl[N_LVL][0][i] & w_lvl[N_LVL][1][i])
                      | (w_c[i] & (w_lvl[N_LVL][0][i] ^ w_lvl[N_LVL][1][i]));
    end
  end
  if (OUT_REG != 0) begin : g_reg
    logic [W_OUT_X-1:0] r_x;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) r_x <= '0;
      else     r_x <= w_sum;
    end
    assign out_x = r_x;
  end else begin : g_comb
    logic w_unused;
    assign w_unused = clk ^ rst;
    assign out_x    = w_sum;
  end
endmodule

// File: tb/tb_int_mult.sv
// tb_int_mult: scoreboard bench for int_mult; 8x5 combinational and registered builds
// plus 2x2, 3x16, 16x3 and 16x16 combinational builds.
module tb_int_mult;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  a8;
  logic [4:0]  b5;
  logic [1:0]  a2, b2;
  logic [2:0]  a3;
  logic [15:0] b16, c16;
  logic [12:0] x_c, x_r;
  logic [3:0]  x22;
  logic [18:0] x316, x163;
  logic [31:0] x1616;
  int n_tests = 0;
  int n_fail  = 0;
  typedef struct {
    logic [12:0] e8;
    logic [3:0]  e22;
    logic [18:0] e316;
    logic [18:0] e163;
    logic [31:0] e1616;
  } exp_t;
  exp_t        q_exp [$];
  logic [12:0] q_reg [$];
  int_mult #(.W_IN_A(8),  .W_IN_B(5),  .OUT_REG(0)) u_c    (.clk(clk), .rst(rst), .in_a(a8),  .in_b(b5),  .out_x(x_c));
  int_mult #(.W_IN_A(8),  .W_IN_B(5),  .OUT_REG(1)) u_r    (.clk(clk), .rst(rst), .in_a(a8),  .in_b(b5),  .out_x(x_r));
  int_mult #(.W_IN_A(2),  .W_IN_B(2),  .OUT_REG(0)) u_22   (.clk(clk), .rst(rst), .in_a(a2),  .in_b(b2),  .out_x(x22));
  int_mult #(.W_IN_A(3),  .W_IN_B(16), .OUT_REG(0)) u_316  (.clk(clk), .rst(rst), .in_a(a3),  .in_b(b16), .out_x(x316));
  int_mult #(.W_IN_A(16), .W_IN_B(3),  .OUT_REG(0)) u_163  (.clk(clk), .rst(rst), .in_a(b16), .in_b(a3),  .out_x(x163));
  int_mult #(.W_IN_A(16), .W_IN_B(16), .OUT_REG(0)) u_1616 (.clk(clk), .rst(rst), .in_a(b16), .in_b(c16), .out_x(x1616));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [7:0] a, input logic [4:0] b, input logic [12:0] e);
    exp_t   ex, got;
    longint p;
    @(posedge clk);
    #1;
    a8  = a;
    b5  = b;
    a2  = 2'($urandom);
    b2  = 2'($urandom);
    a3  = 3'($urandom);
    b16 = 16'($urandom);
    c16 = 16'($urandom);
    ex.e8    = e;
    p        = longint'($signed(a2)) * longint'($signed(b2));
    ex.e22   = p[3:0];
    p        = longint'($signed(a3)) * longint'($signed(b16));
    ex.e316  = p[18:0];
    ex.e163  = p[18:0];
    p        = longint'($signed(b16)) * longint'($signed(c16));
    ex.e1616 = p[31:0];
    q_exp.push_back(ex);
    q_reg.push_back(e);
    @(negedge clk);
    got = q_exp.pop_front();
    chk("x8",    32'(x_c),   32'(got.e8));
    chk("x2x2",  32'(x22),   32'(got.e22));
    chk("x3x16", 32'(x316),  32'(got.e316));
    chk("x16x3", 32'(x163),  32'(got.e163));
    chk("x16x16", x1616,     got.e1616);
    while (q_reg.size() > 1) chk("x8_reg", 32'(x_r), 32'(q_reg.pop_front()));
  endtask
  initial begin
    logic [7:0]  ta;
    logic [4:0]  tb;
    longint      p;
    rst = 1'b1;
    a8  = 8'd127;
    b5  = 5'd15;
    a2  = '0;
    b2  = '0;
    a3  = '0;
    b16 = '0;
    c16 = '0;
    #2;
    chk("rst_async", 32'(x_r), 32'd0);
    chk("comb_in_rst", 32'(x_c), 32'd1905);
    @(negedge clk);
    chk("rst_hold", 32'(x_r), 32'd0);
    rst = 1'b0;
    drive(8'd127, 5'd15,    13'd1905);
    drive(8'd0,   -5'sd7,   13'd0);
    drive(8'h80,  5'b10000, 13'h0800);
    drive(8'h80,  5'd15,    13'h1880);
    drive(8'hFF,  5'h1F,    13'd1);
    drive(8'd1,   5'b10000, 13'h1FF0);
    drive(8'd127, 5'd15,    13'd1905);
    drive(8'd127, 5'd15,    13'd1905);
    #2;
    chk("reg_before_rst", 32'(x_r), 32'd1905);
    rst = 1'b1;
    #1;
    chk("rst_mid_async", 32'(x_r), 32'd0);
    q_reg.delete();
    @(negedge clk);
    chk("rst_mid_hold", 32'(x_r), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      ta = 8'($random);
      tb = 5'($random);
      p  = longint'($signed(ta)) * longint'($signed(tb));
      drive(ta, tb, p[12:0]);
    end
    for (int ia = 0; ia < 256; ia++) begin
      for (int ib = 0; ib < 32; ib++) begin
        ta = 8'(ia);
        tb = 5'(ib);
        p  = longint'($signed(ta)) * longint'($signed(tb));
        drive(ta, tb, p[12:0]);
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
